// File: rtl/axis_pack_upsize.sv
// Packs RATIO narrow AXI-stream words into one registered wide word, lane 0 first.
// Optional macro AXIS_PACK_TLAST_EN adds tlast early-flush with m_axis_tlast/m_axis_tcnt.
module axis_pack_upsize #(
   parameter  int IN_WIDTH  = 24,
   parameter  int RATIO     = 3,
   localparam int OUT_WIDTH = IN_WIDTH * RATIO,
   localparam int TW        = $clog2(RATIO + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [IN_WIDTH-1:0]  s_axis_tdata,
`ifdef AXIS_PACK_TLAST_EN
   input  logic                 s_axis_tlast,
   output logic                 m_axis_tlast,
   output logic [TW-1:0]        m_axis_tcnt,
`endif
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [OUT_WIDTH-1:0] m_axis_tdata
);

   localparam int            CW        = $clog2(RATIO);
   localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

   logic [CW-1:0]        cnt_reg;
   logic                 ready_en_reg;
   logic                 m_valid_reg;
   logic [OUT_WIDTH-1:0] m_data_reg;
   logic [OUT_WIDTH-1:0] pack_next;
   logic                 flush;
   logic                 end_lane;
   logic                 s_hs;
   logic                 load;

`ifdef AXIS_PACK_TLAST_EN
   logic                 m_last_reg;
   logic [TW-1:0]        m_cnt_reg;

   assign flush = s_axis_tlast;
`else
   assign flush = 1'b0;
`endif

   // Only the word that completes (or flushes) a packet can be blocked by a held output.
   assign end_lane      = (cnt_reg == LAST_LANE) | flush;
   assign s_axis_tready = ready_en_reg & (~end_lane | ~m_valid_reg | m_axis_tready);
   assign s_hs          = s_axis_tvalid & s_axis_tready;
   assign load          = s_hs & end_lane;

   // Lanes below the counter come from the accumulator, the current lane from the
   // input, and lanes above it are zero (only reachable on an early flush).
   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : gen_lane
         if (gi < RATIO - 1) begin : gen_acc
            logic [IN_WIDTH-1:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  lane_reg <= '0;
               else if (s_hs && !load && cnt_reg == CW'(gi))
                  lane_reg <= s_axis_tdata;
            end

            assign pack_next[gi*IN_WIDTH +: IN_WIDTH] =
               (cnt_reg == CW'(gi)) ? s_axis_tdata :
               (cnt_reg >  CW'(gi)) ? lane_reg     : '0;
         end else begin : gen_top
            assign pack_next[gi*IN_WIDTH +: IN_WIDTH] =
               (cnt_reg == LAST_LANE) ? s_axis_tdata : '0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         if (load)
            cnt_reg <= '0;
         else if (s_hs)
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // A load in the same cycle as an output handshake replaces the word without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
      end else if (load) begin
         m_valid_reg <= 1'b1;
         m_data_reg  <= pack_next;
      end else if (m_axis_tready) begin
         m_valid_reg <= 1'b0;
      end
   end

`ifdef AXIS_PACK_TLAST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_last_reg <= 1'b0;
         m_cnt_reg  <= '0;
      end else if (load) begin
         m_last_reg <= s_axis_tlast;
         m_cnt_reg  <= TW'(cnt_reg) + TW'(1);
      end
   end

   assign m_axis_tlast = m_last_reg;
   assign m_axis_tcnt  = m_cnt_reg;
`endif

   assign m_axis_tvalid = m_valid_reg;
   assign m_axis_tdata  = m_data_reg;

endmodule
